// File: rtl/fft_ram_writer.sv
// fft_ram_writer: packs one FFT frame into FFT_RAM, then stalls the FFT core until freqdetect is done.
// Optional sop/eop framing checks are compiled in when WRITER_ERRCHK_EN is defined.
module fft_ram_writer #(
    parameter int NPOINT = 1024,
    parameter int AW     = 10,
    parameter int DW     = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fft_valid,
    input  logic            fft_sop,
    input  logic            fft_eop,
    input  logic [DW-1:0]   fft_real,
    input  logic [DW-1:0]   fft_imag,
    output logic            fft_ready,
    output logic            ramwren,
    output logic [AW-1:0]   ramwraddr,
    output logic [2*DW-1:0] ramdata,
    output logic            fftdone,
    input  logic            detectdone,
    output logic            busy,
    output logic [7:0]      framecnt,
    output logic            frame_err
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE, WAIT_DETECT} state_t;

    state_t            state_q, state_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ready_q, ready_d, wren_q, wren_d, done_q, done_d, busy_q, busy_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [2*DW-1:0]   data_q, data_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              acc, last;
`ifdef WRITER_ERRCHK_EN
    logic              err_q, err_d;
`endif

    assign acc  = fft_valid & ready_q;
    assign last = cnt_q == (AW+1)'(NPOINT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        fcnt_d  = fcnt_q;
`ifdef WRITER_ERRCHK_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: if (acc && fft_sop) begin
                wren_d  = 1'b1;
                addr_d  = '0;
                data_d  = {fft_real, fft_imag};
                cnt_d   = (AW+1)'(1);
                state_d = CAPTURE;
            end
            CAPTURE: if (acc) begin
                wren_d = 1'b1;
                addr_d = cnt_q[AW-1:0];
                data_d = {fft_real, fft_imag};
                cnt_d  = cnt_q + (AW+1)'(1);
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
`ifdef WRITER_ERRCHK_EN
                // A stray sop restarts the frame; an early eop aborts it unwritten.
                if (fft_sop) begin
                    err_d   = 1'b1;
                    addr_d  = '0;
                    cnt_d   = (AW+1)'(1);
                    state_d = CAPTURE;
                end else if (fft_eop && !last) begin
                    err_d   = 1'b1;
                    wren_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (last && !fft_eop) begin
                    err_d   = 1'b1;
                end
`endif
            end
            DONE: begin
                done_d  = 1'b1;
                fcnt_d  = fcnt_q + 8'd1;
                state_d = WAIT_DETECT;
            end
            WAIT_DETECT: if (detectdone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) || (state_d == CAPTURE);
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef WRITER_ERRCHK_EN
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign frame_err = err_q;
`else
    logic unused_eop;
    assign unused_eop = fft_eop;
    assign frame_err  = 1'b0;
`endif

    assign fft_ready = ready_q;
    assign ramwren   = wren_q;
    assign ramwraddr = addr_q;
    assign ramdata   = data_q;
    assign fftdone   = done_q;
    assign busy      = busy_q;
    assign framecnt  = fcnt_q;
endmodule
